// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit half of the peripheral UART. Bytes written over the register bus
//   are queued in a small FIFO and serialised as 8N1 frames (start bit, data
//   LSB first, stop bit) on uart_txd. Back-to-back frames are contiguous.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous active-low reset
//   tx_wr        in   1      write strobe, tx_data valid with it
//   tx_data      in   8      byte to enqueue
//   tx_full      out  1      FIFO holds FIFO_DEPTH entries
//   tx_empty     out  1      FIFO holds no entries
//   tx_count     out  CNT_W  queued entries (excludes byte being shifted)
//   tx_busy      out  1      frame in progress
//   tx_done      out  1      one-cycle pulse after each stop bit
//   tx_overflow  out  1      one-cycle pulse when a write was dropped
//   uart_txd     out  1      serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_wr,
    input  logic [7:0]       tx_data,
    output logic             tx_full,
    output logic             tx_empty,
    output logic [CNT_W-1:0] tx_count,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_overflow,
    output logic             uart_txd
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_ovf;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_txd;
    logic              r_busy;
    logic              r_done;

    logic              w_push;
    logic              w_pop;
    logic              w_baud_last;
    logic [CNT_W-1:0]  w_count_next;
    state_t            w_state_next;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        w_shift_next;
    logic              w_txd_next;
    logic              w_done_next;

    // A write is judged against the registered full flag, so a pop at the
    // same edge cannot rescue a write aimed at a full FIFO.
    assign w_push      = tx_wr & ~r_full;
    assign w_baud_last = (r_baud == BAUD_LAST);

    // Next FIFO occupancy from push/pop of this cycle.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO pointers, occupancy flags and overflow pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
            r_empty <= (w_count_next == '0);
            r_ovf   <= tx_wr & r_full;
        end
    end

    // FIFO storage; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // Frame sequencer next-state, pop request and datapath updates.
    always_comb begin
        w_state_next   = r_state;
        w_pop          = 1'b0;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_baud_next    = '0;
        w_done_next    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_state_next = ST_START;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_bit_idx_next = 3'd0;
                    w_state_next   = ST_DATA;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    w_done_next = 1'b1;
                    // Chain straight into the next start bit when data waits.
                    if (!r_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from the next state so the
    // registered output lines up with the state change.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            ST_START: w_txd_next = 1'b0;
            ST_DATA:  w_txd_next = w_shift_next[0];
            default:  w_txd_next = 1'b1;
        endcase
    end

    // Sequencer state, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= w_done_next;
        end
    end

    assign tx_full     = r_full;
    assign tx_empty    = r_empty;
    assign tx_count    = r_count;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_overflow = r_ovf;
    assign uart_txd    = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with a short bit period (16 clocks).
//   A serial receiver model decodes uart_txd into a byte queue; per-cycle
//   FIFO/status behaviour is checked against a table of hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          reset;
    logic          tx_wr;
    logic [7:0]    tx_data;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_overflow;
    logic          uart_txd;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .tx_count   (tx_count),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_overflow(tx_overflow),
        .uart_txd   (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial receiver model: samples mid-bit on the falling clock edge.
    logic [7:0] rx_q[$];
    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_shift;
    int         m_ferr = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         ovf_cnt = 0;
    int         done_t[$];

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (uart_txd == 1'b0) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt % CPB == CPB / 2) begin
                if (m_cnt / CPB == 0) begin
                    if (uart_txd !== 1'b0) m_ferr <= m_ferr + 1;
                end else if (m_cnt / CPB <= 8) begin
                    m_shift[m_cnt / CPB - 1] <= uart_txd;
                end else begin
                    if (uart_txd !== 1'b1) m_ferr <= m_ferr + 1;
                    rx_q.push_back(m_shift);
                    m_busy <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_t.push_back(cyc);
        end
        if (tx_overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end

    typedef struct {
        logic          wr;
        logic [7:0]    data;
        logic          full;
        logic          empty;
        logic [CW-1:0] count;
        logic          ovf;
        logic          busy;
        logic          txd;
    } vec_t;

    vec_t vecs[14];

    task automatic apply_vec(input int i);
        tx_wr   = vecs[i].wr;
        tx_data = vecs[i].data;
        @(posedge clk);
        #1;
        tx_wr = 1'b0;
        chk($sformatf("vec%0d full", i),  tx_full,     vecs[i].full);
        chk($sformatf("vec%0d empty", i), tx_empty,    vecs[i].empty);
        chk($sformatf("vec%0d count", i), tx_count,    vecs[i].count);
        chk($sformatf("vec%0d ovf", i),   tx_overflow, vecs[i].ovf);
        chk($sformatf("vec%0d busy", i),  tx_busy,     vecs[i].busy);
        chk($sformatf("vec%0d txd", i),   uart_txd,    vecs[i].txd);
    endtask

    task automatic write_byte(input logic [7:0] b);
        tx_wr   = 1'b1;
        tx_data = b;
        @(posedge clk);
        #1;
        tx_wr = 1'b0;
    endtask

    task automatic wait_rx(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, " rx timeout"}, (rx_q.size() >= n), 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  frame;
        logic [7:0]  exp_b[$];
        int          d0;
        int          o0;
        int          bad;

        // tx_wr  data   full empty cnt ovf busy txd
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'hB3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'hB4, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hB5, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};

        // T1: writes under reset are ignored; line stays idle after release.
        reset   = 1'b0;
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        repeat (3) begin
            write_byte(8'hFF);
        end
        chk("t1 txd", uart_txd, 1'b1);
        chk("t1 empty", tx_empty, 1'b1);
        chk("t1 full", tx_full, 1'b0);
        chk("t1 count", tx_count, 3'd0);
        chk("t1 busy", tx_busy, 1'b0);
        chk("t1 done", tx_done, 1'b0);
        chk("t1 ovf", tx_overflow, 1'b0);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 20 * CPB; i++) begin
            @(posedge clk);
            #1;
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("t1 idle cycles", bad, 0);
        chk("t1 no rx", rx_q.size(), 0);
        chk("t1 no done", done_cnt, 0);

        // T2: single byte 0x2D, every cycle of the frame checked.
        frame = {1'b1, 8'h2D, 1'b0};
        write_byte(8'h2D);
        chk("t2 txd at write edge", uart_txd, 1'b1);
        for (int k = 1; k <= 10 * CPB + 2; k++) begin
            @(posedge clk);
            #1;
            if (k <= 10 * CPB) begin
                chk($sformatf("t2 txd c%0d", k), uart_txd, frame[(k - 1) / CPB]);
                chk($sformatf("t2 done c%0d", k), tx_done, 1'b0);
            end else begin
                chk($sformatf("t2 txd c%0d", k), uart_txd, 1'b1);
                chk($sformatf("t2 done c%0d", k), tx_done, (k == 10 * CPB + 1));
                chk($sformatf("t2 busy c%0d", k), tx_busy, 1'b0);
            end
        end
        chk("t2 rx size", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t2 rx byte", rx_q.pop_front(), 8'h2D);
        rx_q.delete();
        idle(10);

        // T4: five back-to-back writes, depth 4.
        d0 = done_t.size();
        o0 = ovf_cnt;
        for (int i = 0; i < 6; i++) apply_vec(i);
        wait_rx("t4", 5, 1200);
        idle(20);
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk("t4 rx size", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) chk($sformatf("t4 rx%0d", i), rx_q[i], exp_b[i]);
        end
        chk("t4 done pulses", done_t.size() - d0, 5);
        for (int i = 1; i < 5; i++) begin
            if (d0 + i < done_t.size())
                chk($sformatf("t4 spacing%0d", i), done_t[d0 + i] - done_t[d0 + i - 1], 10 * CPB);
        end
        chk("t4 no overflow", ovf_cnt - o0, 0);
        rx_q.delete();

        // T5: overflow while a frame of 0xA0 is in progress.
        d0 = done_t.size();
        o0 = ovf_cnt;
        for (int i = 6; i < 14; i++) apply_vec(i);
        wait_rx("t5", 5, 1200);
        idle(20);
        exp_b = '{8'hA0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        chk("t5 rx size", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) chk($sformatf("t5 rx%0d", i), rx_q[i], exp_b[i]);
        end
        chk("t5 overflow pulses", ovf_cnt - o0, 1);
        chk("t5 done pulses", done_t.size() - d0, 5);
        chk("t5 empty after", tx_empty, 1'b1);
        rx_q.delete();

        // T6: asynchronous reset during data bit 3 of 0xF0.
        write_byte(8'hF0);
        repeat (70) @(posedge clk);
        #1;
        chk("t6 txd before reset", uart_txd, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("t6 txd async", uart_txd, 1'b1);
        chk("t6 busy async", tx_busy, 1'b0);
        chk("t6 empty async", tx_empty, 1'b1);
        chk("t6 count async", tx_count, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        rx_q.delete();
        idle(5);
        write_byte(8'h7E);
        wait_rx("t6", 1, 400);
        idle(20);
        chk("t6 rx size", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t6 rx byte", rx_q[0], 8'h7E);
        chk("t6 idle after", uart_txd, 1'b1);

        chk("framing errors", m_ferr, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
